dac8_stream_driver: RTL and testbench

- Digital-to-analog counterpart of the flash ADC path. Accepts an 8-bit sample stream over valid/ready and buffers it in a small FIFO.
- Presents one code per programmable sample period on a registered bus. That bus drives the SPICE-side R-2R DAC through the co-simulation boundary.
- Paces output at a fixed rate, holds the last code on starvation, and reports underflows.

---
 rtl/dac_pkg.sv | 14 +
 rtl/dac8_stream_driver_fifo.sv | 44 ++++
 rtl/dac8_stream_driver.sv | 72 +++++++
 tb/tb_dac8_stream_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and helpers for the DAC stream path
package dac_pkg;
    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_DATA_W-1:0] MID_CODE = DEF_DATA_W'(1) << (DEF_DATA_W - 1);
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic logic [31:0] mid_code(input int w);
        return 32'(1) << (w - 1);
    endfunction
    function automatic logic [31:0] to_offset_binary(input logic [31:0] x, input int w);
        return x ^ mid_code(w);
    endfunction
endpackage

// File: rtl/dac8_stream_driver_fifo.sv
// sync_fifo: power-of-2 synchronous FIFO with extra-MSB pointers for full/empty/level
module sync_fifo
    import dac_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    // occupancy is the pointer difference; pushes into full and pops from empty are ignored
    always_comb begin
        level = wr_q - rd_q;
        full  = level == (AW+1)'(DEPTH);
        empty = level == '0;
        wr_d  = wr_q + (AW+1)'(push && !full);
        rd_d  = rd_q + (AW+1)'(pop && !empty);
        dout  = mem_q[rd_q[AW-1:0]];
    end
    // pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    // storage needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dac8_stream_driver.sv
// dac8_stream_driver: FIFO-buffered sample stream paced onto a registered DAC code bus
module dac8_stream_driver
    import dac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter bit SIGNED_IN  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [DIV_W-1:0]                 div,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_W-1:0]                s_data,
    output logic [DATA_W-1:0]                dac_code,
    output logic                             dac_strobe,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level,
    output logic                             underflow,
    output logic [15:0]                      underflow_cnt
);
    localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W));
    logic              full, empty, tick, pop;
    logic [DATA_W-1:0] head;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic              strobe_q, strobe_d, uf_q, uf_d;
    logic [15:0]       ucnt_q, ucnt_d;
    sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (pop),
        .din   (s_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
    assign s_ready = !full;
    // divider tick, pop decision, code update and saturating underflow count
    always_comb begin
        tick     = enable && (cnt_q == '0);
        pop      = tick && !empty;
        cnt_d    = (!enable || tick) ? div : cnt_q - DIV_W'(1);
        code_d   = pop ? (SIGNED_IN ? DATA_W'(to_offset_binary(32'(head), DATA_W)) : head) : code_q;
        strobe_d = pop;
        uf_d     = tick && empty;
        ucnt_d   = (uf_d && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    end
    // output and pacing registers; reset returns to mid-scale silently
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= div;
            code_q   <= MID;
            strobe_q <= 1'b0;
            uf_q     <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            uf_q     <= uf_d;
            ucnt_q   <= ucnt_d;
        end
    end
    assign dac_code      = code_q;
    assign dac_strobe    = strobe_q;
    assign underflow     = uf_q;
    assign underflow_cnt = ucnt_q;
endmodule

// File: tb/tb_dac8_stream_driver.sv
// tb_dac8_stream_driver: directed checks of pacing, buffering, signed conversion, enable and reset
module tb_dac8_stream_driver;
    logic        clk = 0, rst = 0, enable = 0;
    logic [15:0] div = 0;
    logic        s_valid = 0, s_ready, dac_strobe, underflow;
    logic [7:0]  s_data = 0, dac_code;
    logic [4:0]  fifo_level;
    logic [15:0] underflow_cnt;
    logic        sg_valid = 0, sg_ready, sg_strobe, sg_uf;
    logic [7:0]  sg_data = 0, sg_code;
    logic [4:0]  sg_level;
    logic [15:0] sg_ucnt;
    int vectors = 0, errs = 0;

    dac8_stream_driver dut (
        .clk(clk), .rst(rst), .enable(enable), .div(div),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .dac_code(dac_code), .dac_strobe(dac_strobe), .fifo_level(fifo_level),
        .underflow(underflow), .underflow_cnt(underflow_cnt)
    );
    dac8_stream_driver #(.SIGNED_IN(1)) u_sgn (
        .clk(clk), .rst(rst), .enable(enable), .div(div),
        .s_valid(sg_valid), .s_ready(sg_ready), .s_data(sg_data),
        .dac_code(sg_code), .dac_strobe(sg_strobe), .fifo_level(sg_level),
        .underflow(sg_uf), .underflow_cnt(sg_ucnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] d, input logic en);
        rst = 1; div = d; enable = en; s_valid = 0; sg_valid = 0;
        step();
        rst = 0;
    endtask

    initial begin
        int n, uf, k;
        logic [7:0] q[$];
        logic [7:0] exp_s[3];
        // reset state and idle underflow pacing
        do_reset(16'd4, 1'b1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_code", 32'(dac_code), 32'h80);
        chk("rst_strobe", 32'(dac_strobe), 0);
        chk("rst_uf", 32'(underflow), 0);
        chk("rst_ucnt", 32'(underflow_cnt), 0);
        n = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("idle_uf", 32'(underflow), 32'(i % 5 == 0));
            n += 32'(dac_strobe);
        end
        chk("idle_ucnt", 32'(underflow_cnt), 3);
        chk("idle_strobes", 32'(n), 0);
        chk("idle_code", 32'(dac_code), 32'h80);
        // ramp into a full FIFO, drained every 20 cycles
        do_reset(16'd19, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("ramp_ready", 32'(s_ready), 1);
            s_valid = 1; s_data = 8'(i);
            step();
        end
        s_valid = 0;
        chk("ramp_full_ready", 32'(s_ready), 0);
        chk("ramp_full_level", 32'(fifo_level), 16);
        k = 0; uf = 0;
        for (int t = 17; t <= 345; t++) begin
            step();
            if (t == 20) begin
                chk("ramp_ready_back", 32'(s_ready), 1);
                chk("ramp_level15", 32'(fifo_level), 15);
            end
            if (dac_strobe) begin
                chk("ramp_code", 32'(dac_code), 32'(k));
                chk("ramp_time", 32'(t), 32'(20 * (k + 1)));
                k++;
            end
            if (underflow && t < 340) uf++;
        end
        chk("ramp_strobes", 32'(k), 16);
        chk("ramp_early_uf", 32'(uf), 0);
        chk("ramp_ucnt", 32'(underflow_cnt), 1);
        chk("ramp_hold", 32'(dac_code), 32'h0F);
        // line-rate stream at div=0 must reproduce the input sequence
        do_reset(16'd0, 1'b1);
        n = 0; k = 0;
        for (int c = 0; c < 400 && k < 64; c++) begin
            logic pushed;
            s_valid = n < 64;
            s_data = 8'(128 + ((n * 37) % 101) - 50);
            pushed = s_valid && s_ready;
            if (pushed) q.push_back(s_data);
            step();
            if (pushed) n++;
            if (dac_strobe) begin
                chk("stream_code", 32'(dac_code), 32'(q.size() ? q.pop_front() : 8'hxx));
                k++;
            end
        end
        s_valid = 0;
        chk("stream_count", 32'(k), 64);
        // two's complement input converted to offset binary
        do_reset(16'd2, 1'b1);
        exp_s[0] = 8'h00; exp_s[1] = 8'h80; exp_s[2] = 8'hFF;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            sg_valid = c < 3;
            sg_data = c == 0 ? 8'h80 : c == 1 ? 8'h00 : 8'h7F;
            step();
            if (sg_strobe) begin
                chk("signed_code", 32'(sg_code), 32'(exp_s[k % 3]));
                k++;
            end
        end
        sg_valid = 0;
        chk("signed_count", 32'(k), 3);
        // disabled pacing holds queued samples, then resumes after div+1 cycles
        do_reset(16'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 8'(8'hA0 + i);
            step();
        end
        s_valid = 0;
        n = 0; uf = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            n += 32'(dac_strobe);
            uf += 32'(underflow);
        end
        chk("dis_strobes", 32'(n), 0);
        chk("dis_uf", 32'(uf), 0);
        chk("dis_level", 32'(fifo_level), 3);
        enable = 1;
        n = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            step();
            if (dac_strobe) n = c;
        end
        chk("en_first_strobe", 32'(n), 4);
        chk("en_level", 32'(fifo_level), 2);
        chk("en_code", 32'(dac_code), 32'hA0);
        // reset mid-stream discards the queue and returns to mid-scale silently
        do_reset(16'd0, 1'b1);
        s_valid = 1; s_data = 8'h3C;
        step();
        s_valid = 0;
        for (int c = 0; c < 4; c++) step();
        enable = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1; s_data = 8'(8'hD0 + i);
            step();
        end
        s_valid = 0;
        chk("pre_code", 32'(dac_code), 32'h3C);
        chk("pre_level", 32'(fifo_level), 10);
        chk("pre_ucnt_nz", 32'(underflow_cnt != 0), 1);
        rst = 1;
        step();
        rst = 0;
        chk("mid_level", 32'(fifo_level), 0);
        chk("mid_code", 32'(dac_code), 32'h80);
        chk("mid_ready", 32'(s_ready), 1);
        chk("mid_ucnt", 32'(underflow_cnt), 0);
        chk("mid_strobe", 32'(dac_strobe), 0);
        enable = 1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n += 32'(dac_strobe);
        end
        chk("no_stale", 32'(n), 0);
        chk("no_stale_code", 32'(dac_code), 32'h80);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
